// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 transmitter.
// master = command source, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Open-drain only: *_oe=1 pulls a line low, 0 releases it.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2clk,
    input  logic         ps2data,
    output logic         ps2clk_oe,
    output logic         ps2data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t            state_q, state_d;
    logic              clk_meta_q, clk_sync_q;
    logic              dat_meta_q, dat_sync_q;
    logic              filt_q, filt_d;
    logic [FLT_W-1:0]  fcnt_q, fcnt_d;
    logic              fall;
    logic [INH_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic              clk_oe_q, clk_oe_d;
    logic              dat_oe_q, dat_oe_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              aerr_q, aerr_d;
    logic              tout_q, tout_d;
    logic              in_to;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Clock deglitch: accept a new level after FILTER_LEN agreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = clk_sync_q;
                fall   = filt_q & ~clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Timeout window covers the device-clocked part of the transfer.
    assign in_to = (state_q == S_SEND) ||
                   (state_q == S_ACK)  ||
                   (state_q == S_WAITIDLE);

    // Transfer sequencing, line control and status pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        err_d    = err_q;
        done_d   = 1'b0;
        aerr_d   = 1'b0;
        tout_d   = 1'b0;

        if (in_to && (to_q == TO_LAST)) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            tout_d   = 1'b1;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    if (tx.tx_valid) begin
                        shift_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        clk_oe_d = 1'b1;
                        state_d  = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    clk_oe_d = 1'b1;
                    if (cnt_q == INH_LAST) begin
                        dat_oe_d = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_REQ: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    to_d     = '0;
                    bit_d    = '0;
                    state_d  = S_SEND;
                end
                S_SEND: begin
                    to_d = to_q + 1'b1;
                    if (fall) begin
                        dat_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[9:1]};
                        bit_d    = bit_q + 1'b1;
                        if (bit_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    to_d = to_q + 1'b1;
                    if (fall) begin
                        err_d   = dat_sync_q;
                        state_d = S_WAITIDLE;
                    end
                end
                S_WAITIDLE: begin
                    to_d = to_q + 1'b1;
                    if (filt_q && dat_sync_q) begin
                        done_d  = 1'b1;
                        aerr_d  = err_q;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered line/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            aerr_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            err_q    <= err_d;
            done_q   <= done_d;
            aerr_q   <= aerr_d;
            tout_q   <= tout_d;
        end
    end

    assign ps2clk_oe   = clk_oe_q;
    assign ps2data_oe  = dat_oe_q;
    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.busy     = (state_q != S_IDLE);
    assign tx.done     = done_q;
    assign tx.ack_err  = aerr_q;
    assign tx.timeout  = tout_q;

endmodule
